store_write_buffer: RTL and testbench

Buffers committed stores leaving the store queue and writes them to the data cache one word per grant. It sits between the store queue's dcache-facing lanes and the dcache write port. Each store is converted to a word-aligned address with a byte mask, and the block optionally coalesces stores to the same word. It also reports address conflicts so the load path can stall a load that hits a buffered store.

---
 rtl/store_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_write_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - committed-store write buffer feeding the dcache write port
// Same-word coalescing into the youngest entry is enabled by defining STORE_BUF_MERGE_EN.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int LANES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LANES-1:0]        st_valid,
    input  logic [LANES*32-1:0]     st_addr,
    input  logic [LANES*2-1:0]      st_size,
    input  logic [LANES*32-1:0]     st_data,
    output logic [LANES-1:0]        st_accept,
    output logic                    dc_req_valid,
    output logic [31:0]             dc_req_addr,
    output logic [31:0]             dc_req_data,
    output logic [3:0]              dc_req_mask,
    input  logic                    dc_gnt,
    input  logic [31:0]             ld_addr,
    output logic                    ld_conflict,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          ent_valid   [DEPTH];
    logic [29:0]   ent_waddr   [DEPTH];
    logic [31:0]   ent_data    [DEPTH];
    logic [3:0]    ent_mask    [DEPTH];
    logic          valid_n     [DEPTH];
    logic [29:0]   waddr_n     [DEPTH];
    logic [31:0]   data_n      [DEPTH];
    logic [3:0]    mask_n      [DEPTH];

    logic [PW-1:0] head, tail, tail_n;
    logic [CW-1:0] allocs;
    logic          pop;

    logic [29:0]   lane_waddr  [LANES];
    logic [31:0]   lane_data   [LANES];
    logic [3:0]    lane_mask   [LANES];
    logic [LANES-1:0] lane_legal;

    logic          unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Space freed by a pop this cycle is deliberately not visible here.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            st_accept[i] = st_valid[i] && ((DEPTH - int'(count)) > i);
        end
    end

    // Replicate the low bytes across the word, then keep only the enabled lanes.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_waddr[i] = st_addr[i*32+2 +: 30];
            case (st_size[i*2 +: 2])
                2'd0: begin
                    lane_mask[i] = 4'b0001 << st_addr[i*32 +: 2];
                    lane_data[i] = {4{st_data[i*32 +: 8]}};
                end
                2'd1: begin
                    lane_mask[i] = 4'b0011 << {st_addr[i*32+1], 1'b0};
                    lane_data[i] = {2{st_data[i*32 +: 16]}};
                end
                default: begin
                    lane_mask[i] = 4'b1111;
                    lane_data[i] = st_data[i*32 +: 32];
                end
            endcase
            lane_data[i]  = lane_data[i] & expand(lane_mask[i]);
            lane_legal[i] = st_accept[i] && (st_size[i*2 +: 2] != 2'd3);
        end
    end

    assign dc_req_valid = (count != '0);
    assign empty        = (count == '0);
    assign pop          = dc_gnt && dc_req_valid;
    assign dc_req_addr  = dc_req_valid ? {ent_waddr[head], 2'b00} : 32'h0;
    assign dc_req_data  = dc_req_valid ? ent_data[head] : 32'h0;
    assign dc_req_mask  = dc_req_valid ? ent_mask[head] : 4'h0;

    always_comb begin
        ld_conflict = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_valid[e] && (ent_waddr[e] == ld_addr[31:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

`ifdef STORE_BUF_MERGE_EN
    logic [PW-1:0] young;
    logic          young_ok;
`endif

    always_comb begin
        valid_n = ent_valid;
        waddr_n = ent_waddr;
        data_n  = ent_data;
        mask_n  = ent_mask;
        tail_n  = tail;
        allocs  = '0;
`ifdef STORE_BUF_MERGE_EN
        // A lone entry is the presented head, so it must not be merged into.
        young    = tail - PW'(1);
        young_ok = (count >= CW'(2));
`endif
        if (pop) begin
            valid_n[head] = 1'b0;
            waddr_n[head] = '0;
            data_n[head]  = '0;
            mask_n[head]  = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_legal[i]) begin
`ifdef STORE_BUF_MERGE_EN
                if (young_ok && (waddr_n[young] == lane_waddr[i])) begin
                    mask_n[young] = mask_n[young] | lane_mask[i];
                    data_n[young] = (data_n[young] & ~expand(lane_mask[i])) | lane_data[i];
                end else
`endif
                begin
                    valid_n[tail_n] = 1'b1;
                    waddr_n[tail_n] = lane_waddr[i];
                    data_n[tail_n]  = lane_data[i];
                    mask_n[tail_n]  = lane_mask[i];
`ifdef STORE_BUF_MERGE_EN
                    young    = tail_n;
                    young_ok = 1'b1;
`endif
                    tail_n = tail_n + PW'(1);
                    allocs = allocs + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_valid[e] <= 1'b0;
                ent_waddr[e] <= '0;
                ent_data[e]  <= '0;
                ent_mask[e]  <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            ent_valid <= valid_n;
            ent_waddr <= waddr_n;
            ent_data  <= data_n;
            ent_mask  <= mask_n;
            head      <= head + PW'(pop);
            tail      <= tail_n;
            count     <= count + allocs - CW'(pop);
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - table-driven bench with write scoreboard for store_write_buffer
module tb_store_write_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  st_valid = 2'b11;
    logic [63:0] st_addr = '0;
    logic [3:0]  st_size = '0;
    logic [63:0] st_data = '0;
    logic [1:0]  st_accept;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr, dc_req_data;
    logic [3:0]  dc_req_mask;
    logic        dc_gnt = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_conflict, empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    store_write_buffer #(.DEPTH(4), .LANES(2)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .st_accept(st_accept),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask), .dc_gnt(dc_gnt),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .empty(empty), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0; logic [1:0] s0; logic [31:0] d0;
        logic [31:0] a1; logic [1:0] s1; logic [31:0] d1;
        logic        gnt;
        logic [31:0] ld;
        logic [1:0]  acc;
        logic        conf;
        int          cnt;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_w;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        case (s)
            2'd0: begin
                w.mask = 4'b0001 << a[1:0];
                w.data = {24'h0, d[7:0]} << (8 * int'(a[1:0]));
            end
            2'd1: begin
                w.mask = 4'b0011 << {a[1], 1'b0};
                w.data = {16'h0, d[15:0]} << (16 * int'(a[1]));
            end
            default: begin
                w.mask = 4'hF;
                w.data = d;
            end
        endcase
        sb.push_back(w);
    endtask

    function automatic vec_t mk(input logic [1:0] v,
                                input logic [31:0] a0, input logic [1:0] s0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [1:0] s1, input logic [31:0] d1,
                                input logic gnt, input logic [31:0] ld,
                                input logic [1:0] acc, input logic conf, input int cnt);
        vec_t t;
        t.v = v; t.a0 = a0; t.s0 = s0; t.d0 = d0; t.a1 = a1; t.s1 = s1; t.d1 = d1;
        t.gnt = gnt; t.ld = ld; t.acc = acc; t.conf = conf; t.cnt = cnt;
        return t;
    endfunction

    task automatic run_row(input vec_t t, input int idx);
        st_valid = t.v;
        st_addr  = {t.a1, t.a0};
        st_size  = {t.s1, t.s0};
        st_data  = {t.d1, t.d0};
        dc_gnt   = t.gnt;
        ld_addr  = t.ld;
        #1;
        chk($sformatf("row%0d st_accept", idx), st_accept, t.acc);
        chk($sformatf("row%0d ld_conflict", idx), ld_conflict, t.conf);
        if (t.acc[0] && t.s0 != 2'd3) push_exp(t.a0, t.s0, t.d0);
        if (t.acc[1] && t.s1 != 2'd3) push_exp(t.a1, t.s1, t.d1);
        @(posedge clock); #1;
        chk($sformatf("row%0d count", idx), count, t.cnt);
        chk($sformatf("row%0d empty", idx), empty, t.cnt == 0);
        chk($sformatf("row%0d dc_req_valid", idx), dc_req_valid, t.cnt != 0);
    endtask

    always @(negedge clock) begin
        if (!reset && dc_req_valid && dc_gnt) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h required=none", dc_req_addr);
            end else begin
                mon_w = sb.pop_front();
                chk("write addr", dc_req_addr, mon_w.addr);
                chk("write data", dc_req_data, mon_w.data);
                chk("write mask", dc_req_mask, mon_w.mask);
            end
        end
    end

    initial begin
        // single store, byte/half placement, illegal size
        vecs.push_back(mk(2'b01, 32'h1000, 2'd2, 32'hDEADBEEF, 0, 0, 0, 1'b1, 32'hFFF0, 2'b01, 1'b0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'h1000, 2'b00, 1'b1, 0));
        vecs.push_back(mk(2'b01, 32'h2003, 2'd0, 32'h000000AB, 0, 0, 0, 1'b1, 32'hFFF0, 2'b01, 1'b0, 1));
        vecs.push_back(mk(2'b01, 32'h2002, 2'd1, 32'h00001234, 0, 0, 0, 1'b1, 32'h2000, 2'b01, 1'b1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 0));
        vecs.push_back(mk(2'b01, 32'h2500, 2'd3, 32'h00005555, 0, 0, 0, 1'b1, 32'h2500, 2'b01, 1'b0, 0));
        // fill to full with no grant, then drain
        vecs.push_back(mk(2'b11, 32'h5000, 2'd2, 32'hA0A0A0A0, 32'h5004, 2'd2, 32'hA1A1A1A1, 1'b0, 32'hFFF0, 2'b11, 1'b0, 2));
        vecs.push_back(mk(2'b11, 32'h5008, 2'd2, 32'hA2A2A2A2, 32'h500C, 2'd2, 32'hA3A3A3A3, 1'b0, 32'h5004, 2'b11, 1'b1, 4));
        vecs.push_back(mk(2'b11, 32'h5010, 2'd2, 32'hA4A4A4A4, 32'h5014, 2'd2, 32'hA5A5A5A5, 1'b0, 32'h500A, 2'b00, 1'b1, 4));
        vecs.push_back(mk(2'b11, 32'h5010, 2'd2, 32'hA4A4A4A4, 32'h5014, 2'd2, 32'hA5A5A5A5, 1'b1, 32'h5010, 2'b00, 1'b0, 3));
        vecs.push_back(mk(2'b11, 32'h5010, 2'd2, 32'hA4A4A4A4, 32'h5014, 2'd2, 32'hA5A5A5A5, 1'b1, 32'hFFF0, 2'b01, 1'b0, 3));
        vecs.push_back(mk(2'b10, 0, 0, 0, 32'h5014, 2'd2, 32'hA5A5A5A5, 1'b1, 32'hFFF0, 2'b00, 1'b0, 2));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 0));
        // wrap-around: seven stores under continuous grant
        vecs.push_back(mk(2'b11, 32'h6000, 2'd2, 32'h60000000, 32'h6004, 2'd2, 32'h60000001, 1'b1, 32'hFFF0, 2'b11, 1'b0, 2));
        vecs.push_back(mk(2'b11, 32'h6008, 2'd2, 32'h60000002, 32'h600C, 2'd2, 32'h60000003, 1'b1, 32'hFFF0, 2'b11, 1'b0, 3));
        vecs.push_back(mk(2'b11, 32'h6010, 2'd2, 32'h60000004, 32'h6014, 2'd2, 32'h60000005, 1'b1, 32'hFFF0, 2'b01, 1'b0, 3));
        vecs.push_back(mk(2'b01, 32'h6014, 2'd2, 32'h60000005, 0, 0, 0, 1'b1, 32'hFFF0, 2'b01, 1'b0, 3));
        vecs.push_back(mk(2'b01, 32'h6018, 2'd2, 32'h60000006, 0, 0, 0, 1'b1, 32'hFFF0, 2'b01, 1'b0, 3));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 2));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hFFF0, 2'b00, 1'b0, 0));
        // load conflict probes
        vecs.push_back(mk(2'b01, 32'h4000, 2'd2, 32'h44444444, 0, 0, 0, 1'b0, 32'h4002, 2'b01, 1'b0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 32'h4002, 2'b00, 1'b1, 1));
        vecs.push_back(mk(2'b11, 32'h4010, 2'd2, 32'h44440010, 32'h4020, 2'd2, 32'h44440020, 1'b0, 32'h4004, 2'b11, 1'b0, 3));

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset dc_req_valid", dc_req_valid, 0);
        chk("reset dc_req_addr", dc_req_addr, 0);
        chk("reset dc_req_data", dc_req_data, 0);
        chk("reset dc_req_mask", dc_req_mask, 0);
        chk("reset ld_conflict", ld_conflict, 0);
        chk("reset st_accept", st_accept, 2'b11);
        st_valid = 2'b00;

        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

        // mid-operation reset with three entries buffered
        reset    = 1'b1;
        st_valid = 2'b11;
        st_addr  = {32'h4030, 32'h4040};
        st_size  = {2'd2, 2'd2};
        ld_addr  = 32'h4000;
        #1;
        chk("prereset st_accept", st_accept, 2'b01);
        @(posedge clock); #1;
        reset    = 1'b0;
        st_valid = 2'b00;
        sb.delete();
        #1;
        chk("midreset count", count, 0);
        chk("midreset dc_req_valid", dc_req_valid, 0);
        chk("midreset empty", empty, 1);
        chk("midreset ld_conflict", ld_conflict, 0);

        // two byte stores to one word on both lanes in the same cycle
        dc_gnt   = 1'b0;
        st_valid = 2'b11;
        st_addr  = {32'h3001, 32'h3000};
        st_size  = {2'd0, 2'd0};
        st_data  = {32'h00000022, 32'h00000011};
        #1;
        chk("merge st_accept", st_accept, 2'b11);
        @(posedge clock); #1;
        st_valid = 2'b00;
        chk("merge dc_req_addr", dc_req_addr, 32'h3000);
`ifdef STORE_BUF_MERGE_EN
        chk("merge count", count, 1);
        chk("merge dc_req_mask", dc_req_mask, 4'b0011);
        chk("merge dc_req_data", dc_req_data, 32'h00002211);
        sb.push_back('{addr: 32'h3000, data: 32'h00002211, mask: 4'b0011});
`else
        chk("merge count", count, 2);
        chk("merge dc_req_mask", dc_req_mask, 4'b0001);
        chk("merge dc_req_data", dc_req_data, 32'h00000011);
        push_exp(32'h3000, 2'd0, 32'h11);
        push_exp(32'h3001, 2'd0, 32'h22);
`endif
        dc_gnt = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        dc_gnt = 1'b0;
        chk("merge drained count", count, 0);
        chk("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
